// File: rtl/fl_pkg.sv
// Shared definitions for the feature-map load path: sequencer states and
// default geometry used by the banked RAM, the loader and the compute stage.
package fl_pkg;

    // Sequencer states; CLEAR is only reachable in zero-fill builds.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam int FL_SIZE    = 32;
    localparam int FL_WIDTH   = 16;
    localparam int FL_ADDRESS = 10;

endpackage

// File: rtl/bank_write_sequencer.sv
// Port-A loader for the SIZE-bank feature-map RAM. Words arriving on the
// s_valid/s_ready handshake are scattered round-robin: word k lands in bank
// k%SIZE at row k/SIZE. One frame of SIZE*ROWS words per start, then done.
//
// Optional feature: define BANK_WRITE_SEQUENCER_ZERO_FILL_EN to sweep every
// bank address with zeros (CLEAR state) before each frame is loaded.
//
// state | meaning
// IDLE  | waiting for start; nothing accepted
// CLEAR | zero-fill sweep over all 2**ADDRESS rows (zero-fill builds only)
// LOAD  | accepting words, one write strobe per accepted word
// DONE  | single-cycle frame-complete pulse
module bank_write_sequencer
    import fl_pkg::*;
#(
    parameter int SIZE    = FL_SIZE,
    parameter int WIDTH   = FL_WIDTH,
    parameter int ADDRESS = FL_ADDRESS,
    parameter int ROWS    = 2**ADDRESS
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            s_valid,
    input  logic [WIDTH-1:0]                s_data,
    output logic                            s_ready,
    output logic [SIZE-1:0]                 ena,
    output logic [SIZE-1:0]                 wea,
    output logic [SIZE-1:0][ADDRESS-1:0]    addra,
    output logic [SIZE-1:0][WIDTH-1:0]      dina,
    output logic                            busy,
    output logic                            done
);

    localparam int                 BW        = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [BW-1:0]      BANK_LAST = BW'(SIZE - 1);
    localparam logic [ADDRESS-1:0] ROW_LAST  = ADDRESS'(ROWS - 1);

    seq_state_t                     state;
    seq_state_t                     state_next;
    logic [BW-1:0]                  bank_idx;
    logic [BW-1:0]                  bank_next;
    logic [ADDRESS-1:0]             row;
    logic [ADDRESS-1:0]             row_next;
    logic                           accept;
    logic                           last_word;
    logic [SIZE-1:0]                ena_next;
    logic [SIZE-1:0][ADDRESS-1:0]   addra_next;
    logic [SIZE-1:0][WIDTH-1:0]     dina_next;

`ifdef BANK_WRITE_SEQUENCER_ZERO_FILL_EN
    localparam logic [ADDRESS-1:0] CLR_LAST = '1;
    logic [ADDRESS-1:0]            clr_cnt;
    logic [ADDRESS-1:0]            clr_next;
`endif

    // s_ready is a registered decode of LOAD, so accept never loops back
    // combinationally into the ready logic.
    assign accept    = s_valid && s_ready;
    assign last_word = (bank_idx == BANK_LAST) && (row == ROW_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; start outside IDLE is ignored.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef BANK_WRITE_SEQUENCER_ZERO_FILL_EN
                    state_next = CLEAR;
`else
                    state_next = LOAD;
`endif
                end
            end
`ifdef BANK_WRITE_SEQUENCER_ZERO_FILL_EN
            CLEAR: begin
                if (clr_cnt == CLR_LAST) begin
                    state_next = LOAD;
                end
            end
`endif
            LOAD: begin
                if (accept && last_word) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bank/row counters: cleared on entry to LOAD, advanced on each accept.
    always_comb begin
        bank_next = bank_idx;
        row_next  = row;
        if ((state != LOAD) && (state_next == LOAD)) begin
            bank_next = '0;
            row_next  = '0;
        end else if (accept) begin
            if (bank_idx == BANK_LAST) begin
                bank_next = '0;
                if (row != ROW_LAST) begin
                    row_next = row + ADDRESS'(1);
                end
            end else begin
                bank_next = bank_idx + BW'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_idx <= '0;
            row      <= '0;
        end else begin
            bank_idx <= bank_next;
            row      <= row_next;
        end
    end

`ifdef BANK_WRITE_SEQUENCER_ZERO_FILL_EN
    // Clear address: the value shown on addra during the coming CLEAR cycle.
    always_comb begin
        clr_next = clr_cnt;
        if (state_next == CLEAR) begin
            clr_next = (state == CLEAR) ? clr_cnt + ADDRESS'(1) : '0;
        end
    end

    // Clear address register.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt <= '0;
        end else begin
            clr_cnt <= clr_next;
        end
    end
`endif

    // Port-A values for the next cycle; address and data hold when idle.
    always_comb begin
        ena_next   = '0;
        addra_next = addra;
        dina_next  = dina;
        if (accept) begin
            ena_next   = SIZE'(1) << bank_idx;
            addra_next = {SIZE{row}};
            dina_next  = {SIZE{s_data}};
        end
`ifdef BANK_WRITE_SEQUENCER_ZERO_FILL_EN
        else if (state_next == CLEAR) begin
            ena_next   = '1;
            addra_next = {SIZE{clr_next}};
            dina_next  = '0;
        end
`endif
    end

    // Registered outputs; status flags decode the upcoming state so they
    // line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            ena     <= '0;
            wea     <= '0;
            addra   <= '0;
            dina    <= '0;
            s_ready <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            ena     <= ena_next;
            wea     <= ena_next;
            addra   <= addra_next;
            dina    <= dina_next;
            s_ready <= (state_next == LOAD);
            busy    <= (state_next == LOAD) || (state_next == CLEAR);
            done    <= (state_next == DONE);
        end
    end

endmodule
